// File: rtl/msf_frame_decoder.sv
// Assembles one MSF minute frame from per-second A/B bits and validates it at each marker.
// Latency: results one cycle after the marker beat; every beat is accepted, no backpressure.
module msf_frame_decoder (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bits_valid_i,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    output logic       time_valid_o,
    output logic       frame_error_o,
    output logic       locked_o,
    output logic [7:0] year_o,
    output logic [4:0] month_o,
    output logic [5:0] day_o,
    output logic [2:0] dow_o,
    output logic [5:0] hour_o,
    output logic [6:0] minute_o,
    output logic       bst_o
);

    // a_q[0] holds second 59 at marker time, a_q[42] holds second 17.
    logic [42:0] a_q, a_d;
    logic [5:0]  b_q, b_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        time_valid_q, time_valid_d;
    logic        frame_error_q, frame_error_d;
    logic        locked_q, locked_d;
    logic [7:0]  year_q, year_d;
    logic [4:0]  month_q, month_d;
    logic [5:0]  day_q, day_d;
    logic [2:0]  dow_q, dow_d;
    logic [5:0]  hour_q, hour_d;
    logic [6:0]  minute_q, minute_d;
    logic        bst_q, bst_d;

    logic len_ok;
    logic pattern_ok;
    logic parity_ok;
    logic frame_ok;

    always_comb begin
        len_ok     = (cnt_q >= 6'd58) && (cnt_q <= 6'd60);
        // Seconds 52..59 must read 0,1,1,1,1,1,1,0.
        pattern_ok = (a_q[7:0] == 8'b0111_1110);
        parity_ok  = (^{a_q[42:35], b_q[5]}) &
                     (^{a_q[34:24], b_q[4]}) &
                     (^{a_q[23:21], b_q[3]}) &
                     (^{a_q[20:8],  b_q[2]});
        frame_ok   = len_ok && pattern_ok && parity_ok;
    end

    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        time_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        locked_d      = locked_q;
        year_d        = year_q;
        month_d       = month_q;
        day_d         = day_q;
        dow_d         = dow_q;
        hour_d        = hour_q;
        minute_d      = minute_q;
        bst_d         = bst_q;
        if (bits_valid_i) begin
            if (bits_is_second_00_i) begin
                cnt_d = 6'd0;
                if (frame_ok) begin
                    time_valid_d = 1'b1;
                    locked_d     = 1'b1;
                    year_d       = a_q[42:35];
                    month_d      = a_q[34:30];
                    day_d        = a_q[29:24];
                    dow_d        = a_q[23:21];
                    hour_d       = a_q[20:15];
                    minute_d     = a_q[14:8];
                    bst_d        = b_q[1];
                end else begin
                    frame_error_d = 1'b1;
                    locked_d      = 1'b0;
                end
            end else begin
                a_d = {a_q[41:0], bits_data_i[1]};
                b_d = {b_q[4:0],  bits_data_i[0]};
                // Saturation keeps a missed marker from wrapping back into the length window.
                cnt_d = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= 6'd63;
            time_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            locked_q      <= 1'b0;
            year_q        <= '0;
            month_q       <= '0;
            day_q         <= '0;
            dow_q         <= '0;
            hour_q        <= '0;
            minute_q      <= '0;
            bst_q         <= 1'b0;
        end else begin
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            time_valid_q  <= time_valid_d;
            frame_error_q <= frame_error_d;
            locked_q      <= locked_d;
            year_q        <= year_d;
            month_q       <= month_d;
            day_q         <= day_d;
            dow_q         <= dow_d;
            hour_q        <= hour_d;
            minute_q      <= minute_d;
            bst_q         <= bst_d;
        end
    end

    assign time_valid_o  = time_valid_q;
    assign frame_error_o = frame_error_q;
    assign locked_o      = locked_q;
    assign year_o        = year_q;
    assign month_o       = month_q;
    assign day_o         = day_q;
    assign dow_o         = dow_q;
    assign hour_o        = hour_q;
    assign minute_o      = minute_q;
    assign bst_o         = bst_q;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Bench for msf_frame_decoder: frames built from field values, checked against a second-indexed history model.
module tb_msf_frame_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bv = 1'b0;
    logic       bm = 1'b0;
    logic [1:0] bd = 2'b00;
    logic       tv, fe, lk, bst;
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day, hour;
    logic [2:0] dow;
    logic [6:0] minute;

    msf_frame_decoder dut (
        .clk_i(clk), .rst_i(rst), .bits_valid_i(bv), .bits_is_second_00_i(bm),
        .bits_data_i(bd), .time_valid_o(tv), .frame_error_o(fe), .locked_o(lk),
        .year_o(year), .month_o(month), .day_o(day), .dow_o(dow), .hour_o(hour),
        .minute_o(minute), .bst_o(bst)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: full history of data beats since reset, indexed from the end.
    bit ha[$];
    bit hb[$];
    bit seen;
    int cnt;
    logic       e_tv, e_fe, e_lk, e_bst;
    logic [7:0] e_year;
    logic [4:0] e_month;
    logic [5:0] e_day, e_hour;
    logic [2:0] e_dow;
    logic [6:0] e_minute;

    logic [38:0] obs, expv;
    assign obs  = {tv, fe, lk, year, month, day, dow, hour, minute, bst};
    assign expv = {e_tv, e_fe, e_lk, e_year, e_month, e_day, e_dow, e_hour, e_minute, e_bst};

    bit fa[1:59];
    bit fb[1:59];

    function automatic bit m_a(int s);
        int i = ha.size() - 60 + s;
        return (i >= 0) ? ha[i] : 1'b0;
    endfunction

    function automatic bit m_b(int s);
        int i = hb.size() - 60 + s;
        return (i >= 0) ? hb[i] : 1'b0;
    endfunction

    function automatic logic [7:0] fld(int s0, int n);
        logic [7:0] v = 8'd0;
        for (int i = 0; i < n; i++) v = {v[6:0], m_a(s0 + i)};
        return v;
    endfunction

    function automatic bit grp_odd(int s0, int s1, int bs);
        bit x = m_b(bs);
        for (int s = s0; s <= s1; s++) x ^= m_a(s);
        return x;
    endfunction

    task automatic model_reset();
        ha.delete();
        hb.delete();
        seen = 1'b0;
        cnt = 0;
        {e_tv, e_fe, e_lk, e_year, e_month, e_day, e_dow, e_hour, e_minute, e_bst} = '0;
    endtask

    task automatic drive(bit v, bit m, logic [1:0] d);
        bv = v; bm = m; bd = d;
        @(posedge clk); #1;
        bv = 1'b0; bm = 1'b0;
    endtask

    task automatic data_beat(bit a, bit b);
        ha.push_back(a);
        hb.push_back(b);
        if (seen) cnt++;
        e_tv = 1'b0; e_fe = 1'b0;
        drive(1'b1, 1'b0, {a, b});
    endtask

    task automatic idle();
        e_tv = 1'b0; e_fe = 1'b0;
        drive(1'b0, 1'($urandom), 2'($urandom));
    endtask

    task automatic marker();
        bit ok;
        ok = seen && cnt >= 58 && cnt <= 60;
        if (m_a(52) != 1'b0 || m_a(59) != 1'b0) ok = 1'b0;
        for (int s = 53; s <= 58; s++) if (m_a(s) != 1'b1) ok = 1'b0;
        if (!grp_odd(17, 24, 54) || !grp_odd(25, 35, 55) ||
            !grp_odd(36, 38, 56) || !grp_odd(39, 51, 57)) ok = 1'b0;
        e_tv = ok; e_fe = !ok; e_lk = ok;
        if (ok) begin
            e_year = fld(17, 8); e_month = 5'(fld(25, 5)); e_day = 6'(fld(30, 6));
            e_dow = 3'(fld(36, 3)); e_hour = 6'(fld(39, 6)); e_minute = 7'(fld(45, 7));
            e_bst = m_b(58);
        end
        seen = 1'b1;
        cnt = 0;
        drive(1'b1, 1'b1, 2'($urandom));
    endtask

    task automatic build_frame(logic [7:0] y, logic [4:0] mo, logic [5:0] d, logic [2:0] dw,
                               logic [5:0] h, logic [6:0] mi, bit bs);
        for (int s = 1; s <= 59; s++) begin fa[s] = 1'($urandom); fb[s] = 1'($urandom); end
        for (int i = 0; i < 8; i++) fa[17 + i] = y[7 - i];
        for (int i = 0; i < 5; i++) fa[25 + i] = mo[4 - i];
        for (int i = 0; i < 6; i++) fa[30 + i] = d[5 - i];
        for (int i = 0; i < 3; i++) fa[36 + i] = dw[2 - i];
        for (int i = 0; i < 6; i++) fa[39 + i] = h[5 - i];
        for (int i = 0; i < 7; i++) fa[45 + i] = mi[6 - i];
        fa[52] = 1'b0; fa[59] = 1'b0;
        for (int s = 53; s <= 58; s++) fa[s] = 1'b1;
        fb[54] = 1'b1; for (int s = 17; s <= 24; s++) fb[54] ^= fa[s];
        fb[55] = 1'b1; for (int s = 25; s <= 35; s++) fb[55] ^= fa[s];
        fb[56] = 1'b1; for (int s = 36; s <= 38; s++) fb[56] ^= fa[s];
        fb[57] = 1'b1; for (int s = 39; s <= 51; s++) fb[57] ^= fa[s];
        fb[58] = bs;
    endtask

    // extra < 0 drops seconds 16 (and 15); extra > 0 repeats second 16.
    task automatic send_seconds(int s_from, int s_to, int extra, int gap);
        int reps;
        for (int s = s_from; s <= s_to; s++) begin
            reps = 1;
            if (s == 16) reps = 1 + extra;
            if (s == 15 && extra < -1) reps = 0;
            if (reps < 0) reps = 0;
            for (int r = 0; r < reps; r++) begin
                data_beat(fa[s], fb[s]);
                if (gap > 0) repeat ($urandom_range(0, gap)) idle();
            end
        end
    endtask

    task automatic build_ref_frame();
        build_frame(8'h23, 5'h03, 6'h14, 3'd2, 6'h15, 7'h26, 1'b1);
    endtask

    localparam logic [38:0] REF_VALID =
        {1'b1, 1'b0, 1'b1, 8'h23, 5'h03, 6'h14, 3'd2, 6'h15, 7'h26, 1'b1};

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs !== 39'd0) begin
            n_fail++; $display("FAIL reset_state got=%h want=%h", obs, 39'd0);
        end
        marker();
        n_cmp++;
        if (fe !== 1'b1 || lk !== 1'b0 || tv !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_marker got fe=%b lk=%b tv=%b want fe=1 lk=0 tv=0", fe, lk, tv);
        end
        n_cmp++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL reset_first_marker_model got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_valid_frame();
        build_ref_frame();
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (obs !== REF_VALID) begin
            n_fail++; $display("FAIL valid_frame got=%h want=%h", obs, REF_VALID);
        end
        n_cmp++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL valid_frame_model got=%h want=%h", obs, expv);
        end
        idle();
        n_cmp++;
        if (tv !== 1'b0 || fe !== 1'b0 || lk !== 1'b1) begin
            n_fail++; $display("FAIL valid_pulse_width got tv=%b fe=%b lk=%b want 0 0 1", tv, fe, lk);
        end
    endtask

    task automatic test_parity_error();
        build_ref_frame();
        fb[57] = ~fb[57];
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (obs !== {1'b0, 1'b1, 1'b0, REF_VALID[35:0]}) begin
            n_fail++; $display("FAIL parity_error got=%h want=%h", obs, {1'b0, 1'b1, 1'b0, REF_VALID[35:0]});
        end
        n_cmp++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL parity_error_model got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_leap_seconds();
        int ext[4] = '{-1, 1, -2, 2};
        for (int k = 0; k < 4; k++) begin
            build_ref_frame();
            send_seconds(1, 59, ext[k], 0);
            marker();
            n_cmp++;
            if (k < 2 && obs !== REF_VALID) begin
                n_fail++; $display("FAIL leap_valid extra=%0d got=%h want=%h", ext[k], obs, REF_VALID);
            end else if (k >= 2 && (fe !== 1'b1 || tv !== 1'b0 || lk !== 1'b0)) begin
                n_fail++; $display("FAIL leap_reject extra=%0d got fe=%b tv=%b lk=%b want 1 0 0", ext[k], fe, tv, lk);
            end
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL leap_model extra=%0d got=%h want=%h", ext[k], obs, expv);
            end
        end
    endtask

    task automatic test_marker_pattern();
        build_ref_frame();
        fa[59] = 1'b1;
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (fe !== 1'b1 || tv !== 1'b0 || lk !== 1'b0) begin
            n_fail++; $display("FAIL marker_pattern got fe=%b tv=%b lk=%b want 1 0 0", fe, tv, lk);
        end
        n_cmp++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL marker_pattern_model got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_ref_frame();
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (obs !== REF_VALID) begin
            n_fail++; $display("FAIL rstmid_setup got=%h want=%h", obs, REF_VALID);
        end
        send_seconds(1, 30, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== 39'd0) begin
            n_fail++; $display("FAIL rstmid_async_clear got=%h want=%h", obs, 39'd0);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_seconds(31, 59, 0, 0);
        marker();
        n_cmp++;
        if (fe !== 1'b1 || tv !== 1'b0 || lk !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_reject got fe=%b tv=%b lk=%b want 1 0 0", fe, tv, lk);
        end
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (obs !== REF_VALID) begin
            n_fail++; $display("FAIL rstmid_recover got=%h want=%h", obs, REF_VALID);
        end
    endtask

    task automatic test_saturation();
        repeat (70) data_beat(1'($urandom), 1'($urandom));
        build_ref_frame();
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (fe !== 1'b1 || tv !== 1'b0) begin
            n_fail++; $display("FAIL saturation got fe=%b tv=%b want 1 0", fe, tv);
        end
        n_cmp++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL saturation_model got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_back_to_back();
        build_ref_frame();
        send_seconds(1, 59, 0, 0);
        marker();
        n_cmp++;
        if (obs !== REF_VALID) begin
            n_fail++; $display("FAIL b2b_first got=%h want=%h", obs, REF_VALID);
        end
        marker();
        n_cmp++;
        if (obs !== expv || fe !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_marker got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_random();
        logic [7:0] y;
        logic [4:0] mo;
        logic [5:0] d, h;
        logic [6:0] mi;
        int ext, gap, pick;
        for (int it = 0; it < 25; it++) begin
            y  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            mo = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            d  = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
            h  = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            mi = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            build_frame(y, mo, d, 3'($urandom_range(0, 6)), h, mi, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                pick = $urandom_range(17, 63);
                if (pick <= 59) fa[pick] = ~fa[pick];
                else fb[pick - 6] = ~fb[pick - 6];
            end
            ext = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) - 2 : 0;
            gap = $urandom_range(0, 1) * 2;
            send_seconds(1, 59, ext, gap);
            marker();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random_frame it=%0d got=%h want=%h", it, obs, expv);
            end
            idle();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random_idle it=%0d got=%h want=%h", it, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_parity_error();
        test_leap_seconds();
        test_marker_pattern();
        test_reset_mid_frame();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msf_frame_decoder.md
# msf_frame_decoder

Consumes the per-second A/B bit stream produced by the MSF bit decoder and assembles one full minute frame. At each minute marker it validates the frame (length, fixed marker pattern and four odd-parity groups) and, if valid, publishes the BCD date/time for the minute now starting. It sits between the bit decoder and the display/time-keeping logic.

## Interface
- No parameters.
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- bits_valid_i  input  1  one-cycle strobe: one second's bits available
- bits_is_second_00_i  input  1  qualifies bits_valid_i: this beat is the minute marker (second 00)
- bits_data_i  input  2  [1] = A bit, [0] = B bit of the current second
- time_valid_o  output  1  one-cycle pulse: a new valid frame has been published
- frame_error_o  output  1  one-cycle pulse: the frame ending at this marker was rejected
- locked_o  output  1  level: last evaluated frame was valid
- year_o  output  8  BCD year, 00-99
- month_o  output  5  BCD month
- day_o  output  6  BCD day of month
- dow_o  output  3  day of week, 0 = Sunday
- hour_o  output  6  BCD hour
- minute_o  output  7  BCD minute
- bst_o  output  1  summer time flag (58B)

## Operation
- Storage: 43-bit A shift register, 6-bit B shift register and a 6-bit saturating beat counter.
- Non-marker beat (bits_valid_i=1, bits_is_second_00_i=0): shift A in at LSB of A register, B in at LSB of B register; counter += 1, saturating at 63.
- End-referenced indexing: at marker time, the last data beat is second 59. A second s (17..59) is A[59-s]; B second s (54..59) is B[59-s]. Leap seconds (MSF inserts/removes second 16) therefore need no special handling.
- Marker beat (bits_valid_i=1, bits_is_second_00_i=1): evaluate frame; the marker's own data bits are discarded; counter cleared to 0; shift registers not cleared.
- Frame valid iff all of:
  - counter in 58..60
  - A seconds 52..59 equal 0,1,1,1,1,1,1,0
  - odd parity: {A17..A24, B54}; {A25..A35, B55}; {A36..A38, B56}; {A39..A51, B57}
- Field mapping, MSB = lowest second: year A17..A24, month A25..A29, day A30..A35, dow A36..A38, hour A39..A44, minute A45..A51, bst B58.
- Valid: load all time outputs, pulse time_valid_o, set locked_o. Invalid: pulse frame_error_o, clear locked_o, time outputs hold.
- No BCD range checking; values are passed through as received.
- bits_is_second_00_i is ignored when bits_valid_i=0.

## Timing
- Reset values: all outputs 0; counter 63 (no marker seen, so the first marker after reset is always rejected); shift registers 0.
- All outputs are registered. time_valid_o or frame_error_o, together with updated fields and locked_o, appear the cycle after the marker beat and last exactly one cycle.
- time_valid_o and frame_error_o are never high together.
- Back-to-back bits_valid_i on consecutive cycles is supported; each beat is processed independently, with no stall and no ready signal.
- Counter saturates at 63: a missed marker yields a reject, never a wrap into the 58..60 window.
- Reset mid-frame: the partial frame is discarded and counter returns to 63. The next marker after reset gives frame_error_o. The marker after that can validate.

## Test plan
- Reset check: assert rst_i asynchronously mid-clock, then release -> all outputs 0. Send a marker -> frame_error_o pulses, locked_o=0.
- Valid frame: marker, then 59 beats encoding 23-03-14, dow 2, 15:26, BST=1 with correct parity, then marker -> one cycle later time_valid_o=1, year_o=8'h23, month_o=5'h03, day_o=6'h14, dow_o=2, hour_o=6'h15, minute_o=7'h26, bst_o=1, locked_o=1.
- Parity error: same frame with B57 inverted -> frame_error_o=1, locked_o=0, fields still hold the previous frame's values.
- Leap seconds: same frame with 58 data beats (second 16 removed) and with 60 data beats (extra second 16) -> both give time_valid_o with identical fields. With 57 or 61 beats -> frame_error_o.
- Marker pattern: valid frame with A59=1 -> frame_error_o.
- Reset mid-frame: assert rst_i at beat 30 of a valid frame, then complete the remaining beats and send a marker -> frame_error_o. Follow with a full valid frame -> time_valid_o.
